// File: rtl/feature_mem_loader_if.sv
// Stream-in and memory-write-port bundle for the feature memory loader.
// The master modport is the loader; the slave side is the DMA plus the memory.
interface feature_mem_loader_if #(
    parameter int DATA_BUS_WIDTH = 64
);
    logic                      s_valid;
    logic [DATA_BUS_WIDTH-1:0] s_data;
    logic                      s_ready;
    logic                      wr_en;
    logic [3:0]                wr_mem_group;
    logic [3:0]                wr_mem_line;
    logic [DATA_BUS_WIDTH-1:0] o_port;

    modport master (
        input  s_valid, s_data,
        output s_ready, wr_en, wr_mem_group, wr_mem_line, o_port
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready, wr_en, wr_mem_group, wr_mem_line, o_port
    );
endinterface

// File: rtl/feature_mem_loader.sv
// Feature memory write sequencer: full tile load or single-line refresh across groups.
// One cycle from accepted stream beat to wr_en; s_ready is high for the whole LOAD state.
// Optional FEATURE_LOADER_STALL_CNT_EN adds a saturating count of s_valid-low LOAD cycles.
`ifndef Tn
`define Tn 4
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 64
`endif

module feature_mem_loader #(
    parameter int Tn             = `Tn,
    parameter int KERNEL_SIZE    = `KERNEL_SIZE,
    parameter int DATA_BUS_WIDTH = `DATA_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [3:0]           line_sel,
    input  logic [3:0]           last_group,
    feature_mem_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef FEATURE_LOADER_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    typedef enum logic {IDLE, LOAD} state_e;

    state_e                    state_q, state_d;
    logic [3:0]                grp_q, grp_d;
    logic [3:0]                line_q, line_d;
    logic                      mode_q, mode_d;
    logic [3:0]                last_q, last_d;
    logic                      wr_en_q, wr_en_d;
    logic [3:0]                wr_grp_q, wr_grp_d;
    logic [3:0]                wr_line_q, wr_line_d;
    logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic cmd_bad;
    logic cmd_ok;
    logic beat;
    logic line_wrap;

    assign cmd_bad = ({1'b0, last_group} >= 5'(Tn)) ||
                     (mode && ({1'b0, line_sel} >= 5'(KERNEL_SIZE)));
    assign cmd_ok  = (state_q == IDLE) && start && !cmd_bad;
    assign beat    = (state_q == LOAD) && bus.s_valid;
    // In single-line mode every beat finishes a "row", so the group steps each beat.
    assign line_wrap = mode_q || (line_q == 4'(KERNEL_SIZE - 1));

    always_comb begin
        state_d   = state_q;
        grp_d     = grp_q;
        line_d    = line_q;
        mode_d    = mode_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_grp_d  = wr_grp_q;
        wr_line_d = wr_line_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                        mode_d  = mode;
                        last_d  = last_group;
                        grp_d   = 4'd0;
                        line_d  = mode ? line_sel : 4'd0;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_grp_d  = grp_q;
                    wr_line_d = line_q;
                    data_d    = bus.s_data;
                    if (line_wrap && (grp_q == last_q)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (line_wrap) begin
                        grp_d = grp_q + 4'd1;
                        if (!mode_q) begin
                            line_d = 4'd0;
                        end
                    end else begin
                        line_d = line_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grp_q     <= 4'd0;
            line_q    <= 4'd0;
            mode_q    <= 1'b0;
            last_q    <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_grp_q  <= 4'd0;
            wr_line_q <= 4'd0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grp_q     <= grp_d;
            line_q    <= line_d;
            mode_q    <= mode_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_grp_q  <= wr_grp_d;
            wr_line_q <= wr_line_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.s_ready      = (state_q == LOAD);
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_mem_group = wr_grp_q;
    assign bus.wr_mem_line  = wr_line_q;
    assign bus.o_port       = data_q;
    assign busy             = (state_q == LOAD);
    assign done             = done_q;
    assign err              = err_q;

`ifdef FEATURE_LOADER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (cmd_ok) begin
            stall_d = 16'd0;
        end else if ((state_q == LOAD) && !bus.s_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_feature_mem_loader.sv
// Directed bench for feature_mem_loader with Tn=4, KERNEL_SIZE=3, DATA_BUS_WIDTH=64.
module tb_feature_mem_loader;
    localparam int TN = 4;
    localparam int KS = 3;
    localparam int DW = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] line_sel;
    logic [3:0] last_group;
    logic       busy;
    logic       done;
    logic       err;
`ifdef FEATURE_LOADER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wq_g[$];
    int wq_l[$];
    int wq_c[$];
    logic [63:0] wq_d[$];
    bit wq_dn[$];

    feature_mem_loader_if #(.DATA_BUS_WIDTH(DW)) bus();

    feature_mem_loader #(
        .Tn(TN), .KERNEL_SIZE(KS), .DATA_BUS_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .line_sel(line_sel), .last_group(last_group), .bus(bus),
        .busy(busy), .done(done), .err(err)
`ifdef FEATURE_LOADER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (bus.wr_en === 1'b1) begin
            wq_g.push_back(int'(bus.wr_mem_group));
            wq_l.push_back(int'(bus.wr_mem_line));
            wq_d.push_back(bus.o_port);
            wq_c.push_back(cyc);
            wq_dn.push_back(done === 1'b1);
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq_g.delete(); wq_l.delete(); wq_d.delete(); wq_c.delete(); wq_dn.delete();
        done_cnt = 0;
    endtask

    task automatic issue(input logic m, input logic [3:0] ls, input logic [3:0] lg);
        start = 1'b1; mode = m; line_sel = ls; last_group = lg;
        tick();
        start = 1'b0; mode = 1'b0; line_sel = 4'd0; last_group = 4'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_vec++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_status: got busy=%b done=%b err=%b want 0", busy, done, err); end
        n_vec++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b want 0", bus.s_ready); end
        rst = 1'b0;
        issue(1'b0, 4'd0, 4'd3);
        bus.s_valid = 1'b1; bus.s_data = 64'h55;
        tick(); tick();
        bus.s_valid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (bus.wr_en !== 1'b0 || bus.o_port !== 64'd0 || bus.wr_mem_group !== 4'd0 || bus.wr_mem_line !== 4'd0) begin n_bad++; $display("FAIL midload_reset_wrport: got en=%b g=%0d l=%0d d=%h want all 0", bus.wr_en, bus.wr_mem_group, bus.wr_mem_line, bus.o_port); end
        n_vec++; if (busy !== 1'b0 || bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL midload_reset_busy: got busy=%b s_ready=%b want 0", busy, bus.s_ready); end
        rst = 1'b0;
        clear_log();
        bus.s_valid = 1'b1;
        repeat (6) tick();
        bus.s_valid = 1'b0;
        n_vec++; if (wq_g.size() !== 0 || done_cnt !== 0) begin n_bad++; $display("FAIL post_reset_idle: got writes=%0d dones=%0d want 0", wq_g.size(), done_cnt); end
        n_vec++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL post_reset_s_ready: got %b want 0", bus.s_ready); end
    endtask

    task automatic test_full_load();
        clear_log();
        issue(1'b0, 4'd0, 4'd3);
        n_vec++; if (busy !== 1'b1 || bus.s_ready !== 1'b1 || bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL full_start: got busy=%b s_ready=%b wr_en=%b want 1 1 0", busy, bus.s_ready, bus.wr_en); end
        bus.s_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.s_data = 64'(i);
            tick();
            if (i == 0) begin
                n_vec++; if (bus.wr_en !== 1'b1 || bus.o_port !== 64'd0) begin n_bad++; $display("FAIL full_first_latency: got wr_en=%b o_port=%h want 1 0", bus.wr_en, bus.o_port); end
            end
        end
        bus.s_valid = 1'b0;
        n_vec++; if (done !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.wr_en !== 1'b1) begin n_bad++; $display("FAIL full_done: got done=%b busy=%b s_ready=%b wr_en=%b want 1 0 0 1", done, busy, bus.s_ready, bus.wr_en); end
        tick(); tick();
        n_vec++; if (wq_g.size() !== 12) begin n_bad++; $display("FAIL full_count: got %0d writes want 12", wq_g.size()); end
        if (wq_g.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                n_vec++;
                if (wq_g[i] !== i / 3 || wq_l[i] !== i % 3 || wq_d[i] !== 64'(i) || wq_c[i] !== wq_c[0] + i || wq_dn[i] !== (i == 11)) begin
                    n_bad++;
                    $display("FAIL full_write%0d: got g=%0d l=%0d d=%0d cyc+%0d done=%0b want g=%0d l=%0d d=%0d cyc+%0d done=%0b",
                             i, wq_g[i], wq_l[i], wq_d[i], wq_c[i] - wq_c[0], wq_dn[i], i / 3, i % 3, i, i, (i == 11));
                end
            end
        end
        n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_count: got %0d want 1", done_cnt); end
        n_vec++; if (bus.wr_en !== 1'b0 || bus.wr_mem_group !== 4'd3 || bus.wr_mem_line !== 4'd2 || bus.o_port !== 64'd11) begin n_bad++; $display("FAIL full_hold: got en=%b g=%0d l=%0d d=%0d want 0 3 2 11", bus.wr_en, bus.wr_mem_group, bus.wr_mem_line, bus.o_port); end
    endtask

    task automatic test_single_line();
        clear_log();
        issue(1'b1, 4'd2, 4'd1);
        bus.s_valid = 1'b1; bus.s_data = 64'hA;
        tick();
        bus.s_data = 64'hB;
        tick();
        bus.s_valid = 1'b0;
        n_vec++; if (done !== 1'b1 || bus.wr_en !== 1'b1 || bus.wr_mem_group !== 4'd1 || bus.wr_mem_line !== 4'd2 || bus.o_port !== 64'hB) begin n_bad++; $display("FAIL single_last: got done=%b en=%b g=%0d l=%0d d=%h want 1 1 1 2 b", done, bus.wr_en, bus.wr_mem_group, bus.wr_mem_line, bus.o_port); end
        tick();
        n_vec++; if (wq_g.size() !== 2) begin n_bad++; $display("FAIL single_count: got %0d writes want 2", wq_g.size()); end
        else begin
            n_vec++; if (wq_g[0] !== 0 || wq_l[0] !== 2 || wq_d[0] !== 64'hA) begin n_bad++; $display("FAIL single_first: got g=%0d l=%0d d=%h want 0 2 a", wq_g[0], wq_l[0], wq_d[0]); end
        end
        clear_log();
        issue(1'b1, 4'd0, 4'd0);
        bus.s_valid = 1'b1; bus.s_data = 64'h77;
        tick();
        bus.s_valid = 1'b0;
        n_vec++; if (bus.wr_en !== 1'b1 || done !== 1'b1 || bus.o_port !== 64'h77 || bus.wr_mem_group !== 4'd0 || bus.wr_mem_line !== 4'd0) begin n_bad++; $display("FAIL min_cmd: got en=%b done=%b d=%h g=%0d l=%0d want 1 1 77 0 0", bus.wr_en, done, bus.o_port, bus.wr_mem_group, bus.wr_mem_line); end
        tick();
    endtask

    task automatic test_stall();
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        clear_log();
        issue(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            bus.s_valid = pat[i];
            bus.s_data = 64'(100 + i);
            tick();
        end
        bus.s_valid = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL stall_done: got %b want 1", done); end
        tick(); tick();
        n_vec++; if (wq_g.size() !== 3) begin n_bad++; $display("FAIL stall_count: got %0d writes want 3", wq_g.size()); end
        else begin
            n_vec++;
            if (wq_d[0] !== 64'd100 || wq_d[1] !== 64'd103 || wq_d[2] !== 64'd104 || wq_l[0] !== 0 || wq_l[1] !== 1 || wq_l[2] !== 2 || wq_g[2] !== 0) begin
                n_bad++;
                $display("FAIL stall_writes: got (%0d,%0d,%0d) (%0d,%0d,%0d) (%0d,%0d,%0d) want (0,0,100) (0,1,103) (0,2,104)",
                         wq_g[0], wq_l[0], wq_d[0], wq_g[1], wq_l[1], wq_d[1], wq_g[2], wq_l[2], wq_d[2]);
            end
        end
`ifdef FEATURE_LOADER_STALL_CNT_EN
        n_vec++; if (stall_cnt !== 16'd2) begin n_bad++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
`endif
    endtask

    task automatic test_bad_cmd();
        clear_log();
        issue(1'b0, 4'd0, 4'd4);
        n_vec++; if (err !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL bad_group: got err=%b busy=%b s_ready=%b want 1 0 0", err, busy, bus.s_ready); end
        tick();
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL bad_err_pulse: got %b want 0", err); end
        issue(1'b1, 4'd3, 4'd0);
        n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL bad_line: got err=%b busy=%b want 1 0", err, busy); end
        bus.s_valid = 1'b1;
        tick(); tick();
        bus.s_valid = 1'b0;
        n_vec++; if (wq_g.size() !== 0 || done_cnt !== 0) begin n_bad++; $display("FAIL bad_no_write: got writes=%0d dones=%0d want 0", wq_g.size(), done_cnt); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        issue(1'b0, 4'd0, 4'd0);
        bus.s_valid = 1'b1;
        bus.s_data = 64'd1; start = 1'b1; mode = 1'b1; line_sel = 4'd1; last_group = 4'd3;
        tick();
        bus.s_data = 64'd2;
        tick();
        bus.s_data = 64'd3; start = 1'b0;
        tick();
        bus.s_valid = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b want 1", done); end
        issue(1'b0, 4'd0, 4'd0);
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
        bus.s_valid = 1'b1; bus.s_data = 64'd4;
        tick();
        n_vec++; if (bus.wr_en !== 1'b1 || bus.wr_mem_group !== 4'd0 || bus.wr_mem_line !== 4'd0 || bus.o_port !== 64'd4) begin n_bad++; $display("FAIL b2b_restart_addr: got en=%b g=%0d l=%0d d=%0d want 1 0 0 4", bus.wr_en, bus.wr_mem_group, bus.wr_mem_line, bus.o_port); end
        bus.s_data = 64'd5;
        tick();
        bus.s_data = 64'd6;
        tick();
        bus.s_valid = 1'b0;
        tick();
        n_vec++; if (wq_g.size() !== 6 || done_cnt !== 2) begin n_bad++; $display("FAIL b2b_count: got writes=%0d dones=%0d want 6 2", wq_g.size(), done_cnt); end
        else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++; if (wq_g[i] !== 0 || wq_l[i] !== i % 3 || wq_d[i] !== 64'(i + 1)) begin n_bad++; $display("FAIL b2b_write%0d: got g=%0d l=%0d d=%0d want 0 %0d %0d", i, wq_g[i], wq_l[i], wq_d[i], i % 3, i + 1); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; line_sel = 4'd0; last_group = 4'd0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        test_reset();
        test_full_load();
        test_single_line();
        test_stall();
        test_bad_cmd();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
